uart_cmd_responder: RTL and testbench
=====================================

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter DATA_LENGTH, default 8, SHALL set the FIFO byte width; only the value 8 is supported.
REQ-002 Parameter NUM_REGS, default 16, SHALL set the register-file depth; address compare uses 8 bits.
REQ-003 Port clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port rx_empty  in  1  SHALL be the RX FIFO empty flag.
REQ-006 Port receive_data  in  DATA_LENGTH  SHALL be the RX FIFO head byte; valid whenever rx_empty=0.
REQ-007 Port rd_uart  out  1  SHALL be a one-cycle pop strobe to the RX FIFO.
REQ-008 Port tx_full  in  1  SHALL be the TX FIFO full flag.
REQ-009 Port wr_uart  out  1  SHALL be a one-cycle push strobe to the TX FIFO.
REQ-010 Port transmit_data  out  DATA_LENGTH  SHALL carry the response byte and be valid while wr_uart=1.
REQ-011 Port regs_flat  out  NUM_REGS*8  SHALL expose the register file; reg i occupies bits [8i+7:8i].
REQ-012 Port busy  out  1  SHALL be 1 in every state except IDLE.
REQ-013 Port err_count  out  8  SHALL be a saturating count of rejected commands.

Function
REQ-014 Protocol SHALL be: write = 0x57, addr, data -> response 0x4B; read = 0x52, addr -> response reg[addr]; any other opcode -> response 0x3F.
REQ-015 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, SEND.
REQ-016 rd_uart SHALL equal (state in IDLE/GET_ADDR/GET_DATA) AND rx_empty=0, combinationally; each byte is captured on the same edge it is popped.
REQ-017 IDLE with pop: opcode 0x57 or 0x52 -> GET_ADDR; otherwise resp=0x3F, err_count+1, -> SEND.
REQ-018 GET_ADDR with pop: write opcode -> latch addr, -> GET_DATA; read opcode with addr<NUM_REGS -> resp=reg[addr], -> SEND; read opcode with addr>=NUM_REGS -> resp=0x3F, err_count+1, -> SEND.
REQ-019 GET_DATA with pop: addr<NUM_REGS -> reg[addr]=data, resp=0x4B; else no register change, resp=0x3F, err_count+1; -> SEND in both cases.
REQ-020 SEND: wr_uart SHALL equal NOT tx_full; on push -> IDLE; while tx_full=1 the FSM SHALL hold SEND with resp stable and no RX pops.
REQ-021 Latency: wr_uart SHALL assert in the cycle after the final command byte's pop when tx_full=0.
REQ-022 An empty RX FIFO SHALL stall any receive state indefinitely, with no timeout.
REQ-023 A read SHALL return the register value as it stands when the address byte is popped.
REQ-024 err_count SHALL saturate at 0xFF.

Reset
REQ-025 On reset assertion, state SHALL go to IDLE and all registers, resp, latched addr/opcode and err_count SHALL go to 0.
REQ-026 During reset, rd_uart=0, wr_uart=0 and busy=0.
REQ-027 Reset mid-command SHALL discard the partial command; bytes already popped are not replayed.

Structure
REQ-028 Package uart_cmd_pkg SHALL hold the opcode constants (0x57, 0x52), response constants (0x4B, 0x3F) and the FSM state encoding.
REQ-029 Sub-module uart_cmd_regfile SHALL implement the NUM_REGS x 8 register file: one write port, one combinational read port, flat output.
REQ-030 The parent SHALL contain only the FSM, the err_count counter and the response register.

Verification
REQ-031 Feed 57 03 A5, tx_full=0 -> reg3=0xA5; one push of 0x4B exactly 1 cycle after the third pop.
REQ-032 Feed 52 03 after REQ-031 -> one push of 0xA5; err_count unchanged.
REQ-033 Feed 13, then 52 20 -> pushes 0x3F, 0x3F; err_count=2; regs unchanged.
REQ-034 Feed 57 05 11 with tx_full=1 for 10 cycles -> reg5=0x11; wr_uart=0 and rd_uart=0 during stall; one push of 0x4B on the first cycle tx_full=0.
REQ-035 Feed 57 02, then assert reset for 1 cycle, then feed 52 02 -> one response, 0x00; no 0x4B is ever emitted.
REQ-036 Feed 0x90 three hundred times -> err_count=0xFF and 300 pushes of 0x3F.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               UART command responder (opcodes, response codes, states).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Command opcodes ('W' and 'R')
    localparam logic [7:0] c_op_write = 8'h57;
    localparam logic [7:0] c_op_read  = 8'h52;

    // Response bytes ('K' acknowledge, '?' rejected)
    localparam logic [7:0] c_resp_ack = 8'h4B;
    localparam logic [7:0] c_resp_err = 8'h3F;

    // Saturation ceiling of the rejected-command counter
    localparam logic [7:0] c_err_max  = 8'hFF;

    // Command FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GET_ADDR = 2'd1,
        ST_GET_DATA = 2'd2,
        ST_SEND     = 2'd3
    } state_t;

    // True when an 8-bit address selects an existing register
    function automatic logic addr_in_range(input logic [7:0] addr, input int num_regs);
        logic [8:0] w_limit;
        w_limit = num_regs[8:0];
        return ({1'b0, addr} < w_limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_regfile
// Description : NUM_REGS x 8-bit register file with one synchronous write
//               port, one combinational read port and a flat view of all
//               registers. Out-of-range accesses are ignored / read as 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_wr_addr,
    input  logic [7:0]            i_wr_data,
    input  logic [7:0]            i_rd_addr,
    output logic [7:0]            o_rd_data,
    output logic [NUM_REGS*8-1:0] o_regs_flat
);

    // Index width wide enough to address every register (at least one bit)
    localparam int c_idx_w = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [7:0] r_regs [NUM_REGS];

    // Register storage: cleared on reset, written only for in-range addresses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (i_wr_en && addr_in_range(i_wr_addr, NUM_REGS)) begin
            r_regs[i_wr_addr[c_idx_w-1:0]] <= i_wr_data;
        end
    end

    // Combinational read; addresses past the end return zero
    always_comb begin
        o_rd_data = 8'h00;
        if (addr_in_range(i_rd_addr, NUM_REGS)) begin
            o_rd_data = r_regs[i_rd_addr[c_idx_w-1:0]];
        end
    end

    // Flat export: register i lives in bits [8i+7:8i]
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign o_regs_flat[8*gi +: 8] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_responder
// Description : Byte-oriented command responder sitting between an RX and a
//               TX UART FIFO. Accepts write (57 addr data -> 4B) and read
//               (52 addr -> reg[addr]) commands; anything else answers 3F and
//               bumps a saturating error counter. DATA_LENGTH must be 8.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int NUM_REGS    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_empty,
    input  logic [DATA_LENGTH-1:0] receive_data,
    output logic                   rd_uart,
    input  logic                   tx_full,
    output logic                   wr_uart,
    output logic [DATA_LENGTH-1:0] transmit_data,
    output logic [NUM_REGS*8-1:0]  regs_flat,
    output logic                   busy,
    output logic [7:0]             err_count
);

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_opcode;
    logic [7:0] r_addr;
    logic [7:0] r_resp;
    logic [7:0] r_err_count;

    logic [7:0] w_rx_byte;
    logic [7:0] w_rd_data;
    logic       w_rx_avail;
    logic       w_tx_ready;
    logic       w_load_opcode;
    logic       w_load_addr;
    logic       w_load_resp;
    logic [7:0] w_resp_next;
    logic       w_err_inc;
    logic       w_reg_we;

    assign w_rx_byte     = receive_data;
    assign transmit_data = r_resp;
    assign err_count     = r_err_count;

    // Strobes are masked while reset is held so the FIFOs see no traffic
    assign w_rx_avail = !rx_empty && !reset;
    assign w_tx_ready = !tx_full  && !reset;

    // The head byte doubles as the read address, so a read returns the
    // register contents as they stand on the edge the address is popped.
    uart_cmd_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .rst         (reset),
        .i_wr_en     (w_reg_we),
        .i_wr_addr   (r_addr),
        .i_wr_data   (w_rx_byte),
        .i_rd_addr   (w_rx_byte),
        .o_rd_data   (w_rd_data),
        .o_regs_flat (regs_flat)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, FIFO strobes and datapath load controls
    always_comb begin
        w_state_next  = r_state;
        rd_uart       = 1'b0;
        wr_uart       = 1'b0;
        busy          = 1'b1;
        w_load_opcode = 1'b0;
        w_load_addr   = 1'b0;
        w_load_resp   = 1'b0;
        w_resp_next   = r_resp;
        w_err_inc     = 1'b0;
        w_reg_we      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_rx_avail) begin
                    rd_uart       = 1'b1;
                    w_load_opcode = 1'b1;
                    if (w_rx_byte == c_op_write || w_rx_byte == c_op_read) begin
                        w_state_next = ST_GET_ADDR;
                    end else begin
                        w_load_resp  = 1'b1;
                        w_resp_next  = c_resp_err;
                        w_err_inc    = 1'b1;
                        w_state_next = ST_SEND;
                    end
                end
            end

            ST_GET_ADDR: begin
                if (w_rx_avail) begin
                    rd_uart = 1'b1;
                    if (r_opcode == c_op_write) begin
                        w_load_addr  = 1'b1;
                        w_state_next = ST_GET_DATA;
                    end else begin
                        w_load_resp  = 1'b1;
                        w_state_next = ST_SEND;
                        if (addr_in_range(w_rx_byte, NUM_REGS)) begin
                            w_resp_next = w_rd_data;
                        end else begin
                            w_resp_next = c_resp_err;
                            w_err_inc   = 1'b1;
                        end
                    end
                end
            end

            ST_GET_DATA: begin
                if (w_rx_avail) begin
                    rd_uart      = 1'b1;
                    w_load_resp  = 1'b1;
                    w_state_next = ST_SEND;
                    if (addr_in_range(r_addr, NUM_REGS)) begin
                        w_reg_we    = 1'b1;
                        w_resp_next = c_resp_ack;
                    end else begin
                        w_resp_next = c_resp_err;
                        w_err_inc   = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (w_tx_ready) begin
                    wr_uart      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command latches, response register and saturating error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode    <= 8'h00;
            r_addr      <= 8'h00;
            r_resp      <= 8'h00;
            r_err_count <= 8'h00;
        end else begin
            if (w_load_opcode) begin
                r_opcode <= w_rx_byte;
            end
            if (w_load_addr) begin
                r_addr <= w_rx_byte;
            end
            if (w_load_resp) begin
                r_resp <= w_resp_next;
            end
            if (w_err_inc && (r_err_count != c_err_max)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_responder
// Description : Self-checking bench for uart_cmd_responder. Models the RX and
//               TX FIFOs with queues and predicts responses, register
//               contents and the error count from whole commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx_empty;
    logic [7:0]   receive_data;
    logic         rd_uart;
    logic         tx_full;
    logic         wr_uart;
    logic [7:0]   transmit_data;
    logic [127:0] regs_flat;
    logic         busy;
    logic [7:0]   err_count;

    uart_cmd_responder #(
        .DATA_LENGTH (8),
        .NUM_REGS    (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_empty      (rx_empty),
        .receive_data  (receive_data),
        .rd_uart       (rd_uart),
        .tx_full       (tx_full),
        .wr_uart       (wr_uart),
        .transmit_data (transmit_data),
        .regs_flat     (regs_flat),
        .busy          (busy),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // FIFO models and logs
    logic [7:0] srcq[$];   // bytes waiting to enter the RX FIFO
    logic [7:0] rxq[$];    // RX FIFO contents seen by the DUT
    logic [7:0] txq[$];    // bytes pushed by the DUT
    int         txc[$];    // cycle of each push
    int         popc[$];   // cycle of each pop
    int         cyc;
    bit         gaps;
    bit         rand_full;
    bit         force_full;

    // Reference model
    logic [7:0] m_regs [16];
    int         m_err;
    logic [7:0] expq[$];

    int vectors;
    int miscompares;

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_err = 0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err = m_err + 1;
    endtask

    // Queue one complete command and predict its response
    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        srcq.push_back(op);
        if (op == 8'h57) begin
            srcq.push_back(a);
            srcq.push_back(d);
            if (a < 8'd16) begin
                m_regs[a[3:0]] = d;
                expq.push_back(8'h4B);
            end else begin
                expq.push_back(8'h3F);
                model_err();
            end
        end else if (op == 8'h52) begin
            srcq.push_back(a);
            if (a < 8'd16) begin
                expq.push_back(m_regs[a[3:0]]);
            end else begin
                expq.push_back(8'h3F);
                model_err();
            end
        end else begin
            expq.push_back(8'h3F);
            model_err();
        end
    endtask

    task automatic drive_rx();
        rx_empty     = (rxq.size() == 0);
        receive_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    task automatic clear_logs();
        txq.delete();
        txc.delete();
        popc.delete();
        expq.delete();
    endtask

    // One clock: sample strobes at negedge, apply FIFO effects after posedge
    task automatic step();
        logic       s_rd;
        logic       s_wr;
        logic [7:0] s_d;
        @(negedge clk);
        s_rd = rd_uart;
        s_wr = wr_uart;
        s_d  = transmit_data;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (s_rd) begin
            if (rxq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_underflow: rd_uart=1 with RX FIFO empty at cycle %0d", cyc);
            end else begin
                void'(rxq.pop_front());
                popc.push_back(cyc);
            end
        end
        if (s_wr) begin
            txq.push_back(s_d);
            txc.push_back(cyc);
        end
        if (srcq.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
            rxq.push_back(srcq.pop_front());
        end
        tx_full = force_full || (rand_full && ($urandom_range(0, 2) == 0));
        drive_rx();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (!(srcq.size() == 0 && rxq.size() == 0 && busy == 1'b0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset      = 1'b1;
        force_full = 1'b0;
        rxq.push_back(8'h52);
        drive_rx();
        tx_full = 1'b0;
        step();
        vectors += 3;
        if (rd_uart !== 1'b0) begin
            miscompares++; $display("FAIL reset_rd_uart: got %b required 0", rd_uart);
        end
        if (wr_uart !== 1'b0) begin
            miscompares++; $display("FAIL reset_wr_uart: got %b required 0", wr_uart);
        end
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        step();
        rxq.delete();
        drive_rx();
        reset = 1'b0;
        model_reset();
        step();
        vectors += 4;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_busy: got %b required 0", busy);
        end
        if (err_count !== 8'h00) begin
            miscompares++; $display("FAIL post_reset_err: got %h required 00", err_count);
        end
        if (regs_flat !== 128'h0) begin
            miscompares++; $display("FAIL post_reset_regs: got %h required 0", regs_flat);
        end
        if (transmit_data !== 8'h00) begin
            miscompares++; $display("FAIL post_reset_resp: got %h required 00", transmit_data);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read();
        clear_logs();
        send_cmd(8'h57, 8'h03, 8'hA5);
        wait_drain(100, "write");
        vectors += 4;
        if (txq.size() != 1) begin
            miscompares++; $display("FAIL write_push_count: got %0d required 1", txq.size());
        end else begin
            if (txq[0] !== 8'h4B) begin
                miscompares++; $display("FAIL write_resp: got %h required 4B", txq[0]);
            end
            if (popc.size() != 3 || txc[0] - popc[popc.size()-1] != 1) begin
                miscompares++;
                $display("FAIL write_latency: pops=%0d push-to-last-pop=%0d required 3 pops and 1",
                         popc.size(), (popc.size() > 0) ? txc[0] - popc[popc.size()-1] : -1);
            end
        end
        if (regs_flat[8*3 +: 8] !== 8'hA5) begin
            miscompares++; $display("FAIL write_reg3: got %h required A5", regs_flat[8*3 +: 8]);
        end

        clear_logs();
        send_cmd(8'h52, 8'h03, 8'h00);
        wait_drain(100, "read");
        vectors += 4;
        if (txq.size() != 1) begin
            miscompares++; $display("FAIL read_push_count: got %0d required 1", txq.size());
        end else begin
            if (txq[0] !== 8'hA5) begin
                miscompares++; $display("FAIL read_resp: got %h required A5", txq[0]);
            end
            if (popc.size() != 2 || txc[0] - popc[popc.size()-1] != 1) begin
                miscompares++; $display("FAIL read_latency: pops=%0d required 2, push 1 cycle after last pop", popc.size());
            end
        end
        if (err_count !== 8'(m_err)) begin
            miscompares++; $display("FAIL read_err: got %h required %h", err_count, 8'(m_err));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_errors();
        clear_logs();
        send_cmd(8'h13, 8'h00, 8'h00);
        send_cmd(8'h52, 8'h20, 8'h00);
        wait_drain(100, "errors");
        vectors += 4;
        if (txq.size() != 2) begin
            miscompares++; $display("FAIL err_push_count: got %0d required 2", txq.size());
        end else if (txq[0] !== 8'h3F || txq[1] !== 8'h3F) begin
            miscompares++; $display("FAIL err_resp: got %h %h required 3F 3F", txq[0], txq[1]);
        end
        if (err_count !== 8'h02) begin
            miscompares++; $display("FAIL err_count2: got %h required 02", err_count);
        end
        if (regs_flat !== model_flat()) begin
            miscompares++; $display("FAIL err_regs: got %h required %h", regs_flat, model_flat());
        end
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL err_busy: got %b required 0", busy);
        end

        // Address boundary: 0x0F is the last register, 0x10 is past the end
        clear_logs();
        send_cmd(8'h57, 8'h0F, 8'h5A);
        send_cmd(8'h52, 8'h0F, 8'h00);
        send_cmd(8'h57, 8'h10, 8'h77);
        send_cmd(8'h52, 8'h10, 8'h00);
        wait_drain(200, "boundary");
        vectors++;
        if (txq.size() != expq.size()) begin
            miscompares++; $display("FAIL bound_push_count: got %0d required %0d", txq.size(), expq.size());
        end
        for (int i = 0; i < txq.size() && i < expq.size(); i++) begin
            vectors++;
            if (txq[i] !== expq[i]) begin
                miscompares++; $display("FAIL bound_resp[%0d]: got %h required %h", i, txq[i], expq[i]);
            end
        end
        vectors += 2;
        if (err_count !== 8'(m_err)) begin
            miscompares++; $display("FAIL bound_err: got %h required %h", err_count, 8'(m_err));
        end
        if (regs_flat !== model_flat()) begin
            miscompares++; $display("FAIL bound_regs: got %h required %h", regs_flat, model_flat());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tx_stall();
        int n_wr_stall;
        clear_logs();
        force_full = 1'b1;
        tx_full    = 1'b1;
        send_cmd(8'h57, 8'h05, 8'h11);
        send_cmd(8'h52, 8'h05, 8'h00);
        n_wr_stall = 0;
        repeat (10) begin
            step();
            if (wr_uart !== 1'b0) n_wr_stall++;
        end
        vectors += 4;
        if (txq.size() != 0 || n_wr_stall != 0) begin
            miscompares++; $display("FAIL stall_wr: pushes=%0d wr_high=%0d required 0", txq.size(), n_wr_stall);
        end
        if (popc.size() != 3 || srcq.size() + rxq.size() != 2) begin
            miscompares++;
            $display("FAIL stall_rd: pops=%0d left=%0d required 3 and 2", popc.size(), srcq.size() + rxq.size());
        end
        if (regs_flat[8*5 +: 8] !== 8'h11) begin
            miscompares++; $display("FAIL stall_reg5: got %h required 11", regs_flat[8*5 +: 8]);
        end
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL stall_busy: got %b required 1", busy);
        end
        force_full = 1'b0;
        tx_full    = 1'b0;
        step();
        vectors++;
        if (txq.size() != 1 || txq[0] !== 8'h4B) begin
            miscompares++;
            $display("FAIL stall_release: pushes=%0d first=%h required 1 push of 4B",
                     txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
        end
        wait_drain(100, "stall");
        vectors++;
        if (txq.size() != 2 || txq[1] !== 8'h11) begin
            miscompares++; $display("FAIL stall_read: pushes=%0d required 2 ending in 11", txq.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int n;
        clear_logs();
        srcq.push_back(8'h57);
        srcq.push_back(8'h02);
        n = 0;
        while (popc.size() < 2 && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (popc.size() != 2) begin
            miscompares++; $display("FAIL mid_pops: got %0d required 2", popc.size());
        end
        do_reset(1);
        send_cmd(8'h52, 8'h02, 8'h00);
        wait_drain(100, "reset_mid");
        vectors += 3;
        if (txq.size() != 1 || txq[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_resp: pushes=%0d first=%h required 1 push of 00",
                     txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
        end
        if (err_count !== 8'h00) begin
            miscompares++; $display("FAIL mid_err: got %h required 00", err_count);
        end
        begin
            int n_ack;
            n_ack = 0;
            foreach (txq[i]) if (txq[i] === 8'h4B) n_ack++;
            if (n_ack != 0) begin
                miscompares++; $display("FAIL mid_no_ack: got %0d 4B pushes required 0", n_ack);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturate();
        int n_bad;
        clear_logs();
        repeat (300) send_cmd(8'h90, 8'h00, 8'h00);
        wait_drain(5000, "saturate");
        n_bad = 0;
        foreach (txq[i]) if (txq[i] !== 8'h3F) n_bad++;
        vectors += 3;
        if (txq.size() != 300) begin
            miscompares++; $display("FAIL sat_push_count: got %0d required 300", txq.size());
        end
        if (n_bad != 0) begin
            miscompares++; $display("FAIL sat_resp: got %0d non-3F pushes required 0", n_bad);
        end
        if (err_count !== 8'hFF) begin
            miscompares++; $display("FAIL sat_err: got %h required FF", err_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic [7:0] op;
        int         k;
        do_reset(2);
        clear_logs();
        gaps      = 1'b1;
        rand_full = 1'b1;
        for (int i = 0; i < 200; i++) begin
            k  = $urandom_range(0, 9);
            op = (k < 4) ? 8'h57 : (k < 8) ? 8'h52 : 8'($urandom_range(0, 255));
            send_cmd(op, 8'($urandom_range(0, 19)), 8'($urandom));
        end
        wait_drain(20000, "random");
        gaps      = 1'b0;
        rand_full = 1'b0;
        step();
        vectors++;
        if (txq.size() != expq.size()) begin
            miscompares++; $display("FAIL rand_push_count: got %0d required %0d", txq.size(), expq.size());
        end
        for (int i = 0; i < txq.size() && i < expq.size(); i++) begin
            vectors++;
            if (txq[i] !== expq[i]) begin
                miscompares++; $display("FAIL rand_resp[%0d]: got %h required %h", i, txq[i], expq[i]);
            end
        end
        vectors += 2;
        if (err_count !== 8'(m_err)) begin
            miscompares++; $display("FAIL rand_err: got %h required %h", err_count, 8'(m_err));
        end
        if (regs_flat !== model_flat()) begin
            miscompares++; $display("FAIL rand_regs: got %h required %h", regs_flat, model_flat());
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        gaps         = 1'b0;
        rand_full    = 1'b0;
        force_full   = 1'b0;
        reset        = 1'b1;
        tx_full      = 1'b0;
        rx_empty     = 1'b1;
        receive_data = 8'h00;
        model_reset();

        test_reset();
        test_write_read();
        test_errors();
        test_tx_stall();
        test_reset_mid();
        test_saturate();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
